// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter,
// DataMemo and the MEM stage.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_CPU   = 2'd0,
      ST_FORCE = 2'd1,
      ST_LOCK  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority, starvation-forced loader
// grants and bounded loader lock bursts.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int LOCK_MAX     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_memR,
   input  logic              cpu_memW,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ld_valid,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_lock,
   output logic              ld_ready,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);
   localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX - 1);

   arb_state_e      state_r, state_nxt_s;
   logic [SW-1:0]   starve_cnt_r, starve_nxt_s;
   logic [LW-1:0]   lock_cnt_r, lock_nxt_s;
   logic            cpu_req_s, grant_ld_s, blocked_s;

   assign cpu_req_s  = cpu_memR | cpu_memW;
   // A handshake is exactly a loader grant, since grant already includes ld_valid.
   assign grant_ld_s = ~reset & ld_valid & ((state_r != ST_CPU) | ~cpu_req_s);
   assign blocked_s  = ~reset & ld_valid & ~grant_ld_s;
   assign ld_ready   = grant_ld_s;
   assign cpu_stall  = cpu_req_s & grant_ld_s;
   assign cpu_rdata  = mem_dout;

   // Memory port mux: loader fields when granted, otherwise the CPU request.
   always_comb begin
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
      if (grant_ld_s) begin
         mem_rd   = ~ld_we;
         mem_wr   = ld_we;
         mem_addr = ld_addr;
         mem_din  = ld_wdata;
      end else if (cpu_req_s & ~reset) begin
         mem_rd = cpu_memR & ~cpu_memW;
         mem_wr = cpu_memW;
      end else begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
   end

   // Next-state, starvation and burst-length logic.
   always_comb begin
      state_nxt_s  = state_r;
      starve_nxt_s = starve_cnt_r;
      lock_nxt_s   = lock_cnt_r;
      case (state_r)
         ST_CPU: begin
            if (grant_ld_s & ld_lock) begin
               state_nxt_s = (LOCK_MAX > 1) ? ST_LOCK : ST_CPU;
               lock_nxt_s  = LW'(1);
            end else if (blocked_s & (starve_cnt_r == STARVE_TOP)) begin
               state_nxt_s = ST_FORCE;
            end else begin
               state_nxt_s = ST_CPU;
            end
         end
         ST_FORCE: begin
            if (grant_ld_s & ld_lock & (LOCK_MAX > 1)) begin
               state_nxt_s = ST_LOCK;
               lock_nxt_s  = LW'(1);
            end else begin
               state_nxt_s = ST_CPU;
            end
         end
         ST_LOCK: begin
            if (grant_ld_s) begin
               lock_nxt_s  = lock_cnt_r + LW'(1);
               state_nxt_s = (~ld_lock | (lock_cnt_r == LOCK_TOP)) ? ST_CPU : ST_LOCK;
            end else begin
               state_nxt_s = ST_LOCK;
            end
         end
         default: begin
            state_nxt_s = ST_CPU;
         end
      endcase

      if (grant_ld_s | ~ld_valid) begin
         starve_nxt_s = {SW{1'b0}};
      end else if ((state_r == ST_CPU) & cpu_req_s & (starve_cnt_r != STARVE_TOP)) begin
         starve_nxt_s = starve_cnt_r + SW'(1);
      end else begin
         starve_nxt_s = starve_cnt_r;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_CPU;
         starve_cnt_r <= {SW{1'b0}};
         lock_cnt_r   <= {LW{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         starve_cnt_r <= starve_nxt_s;
         lock_cnt_r   <= lock_nxt_s;
      end
   end

   // Loader read return: capture on a read handshake, hold data otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_rvalid <= 1'b0;
         ld_rdata  <= {DATA_W{1'b0}};
      end else if (grant_ld_s & ~ld_we) begin
         ld_rvalid <= 1'b1;
         ld_rdata  <= mem_dout;
      end else begin
         ld_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a 64-word behavioural memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_memR, cpu_memW;
   logic [5:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        ld_valid, ld_we, ld_lock, ld_ready, ld_rvalid;
   logic [5:0]  ld_addr;
   logic [31:0] ld_wdata, ld_rdata;
   logic        mem_rd, mem_wr;
   logic [5:0]  mem_addr;
   logic [31:0] mem_din, mem_dout;
   logic [31:0] mem [64];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_LIMIT(4), .LOCK_MAX(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_memR(cpu_memR), .cpu_memW(cpu_memW), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_din;
   end
   assign mem_dout = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic hs;
      int   b;
      reset = 1'b1; cpu_memR = 1'b0; cpu_memW = 1'b0; cpu_addr = 6'd0; cpu_wdata = 32'd0;
      ld_valid = 1'b0; ld_we = 1'b0; ld_addr = 6'd0; ld_wdata = 32'd0; ld_lock = 1'b0;
      step(); step();
      // reset state and output gating
      ld_valid = 1'b1; ld_we = 1'b1; cpu_memR = 1'b1;
      #1;
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_memwr", 32'(mem_wr), 32'd0);
      chk("rst_memrd", 32'(mem_rd), 32'd0);
      chk("rst_rvalid", 32'(ld_rvalid), 32'd0);
      chk("rst_rdata", ld_rdata, 32'd0);
      ld_valid = 1'b0; ld_we = 1'b0; cpu_memR = 1'b0;
      step();
      reset = 1'b0;

      // CPU store/load, loader idle
      cpu_memW = 1'b1; cpu_addr = 6'd5; cpu_wdata = 32'hDEADBEEF;
      #1;
      chk("cpu_st_wr", 32'(mem_wr), 32'd1);
      chk("cpu_st_stall", 32'(cpu_stall), 32'd0);
      step();
      cpu_addr = 6'd30; cpu_wdata = 32'h0BADF00D; cpu_memR = 1'b1;
      #1;
      chk("cpu_rw_rd", 32'(mem_rd), 32'd0);
      chk("cpu_rw_wr", 32'(mem_wr), 32'd1);
      step();
      cpu_memW = 1'b0; cpu_addr = 6'd5;
      #1;
      chk("cpu_ld_data", cpu_rdata, 32'hDEADBEEF);
      chk("cpu_ld_rd", 32'(mem_rd), 32'd1);
      chk("cpu_ld_stall", 32'(cpu_stall), 32'd0);
      step();
      cpu_memR = 1'b0;
      #1;
      chk("idle_rd", 32'(mem_rd), 32'd0);
      chk("idle_wr", 32'(mem_wr), 32'd0);

      // loader write then read, CPU idle
      ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 6'd10; ld_wdata = 32'h12345678;
      #1;
      chk("ld_wr_ready", 32'(ld_ready), 32'd1);
      chk("ld_wr_addr", 32'(mem_addr), 32'd10);
      step();
      ld_we = 1'b0;
      #1;
      chk("ld_rd_ready", 32'(ld_ready), 32'd1);
      chk("ld_rd_memrd", 32'(mem_rd), 32'd1);
      step();
      ld_valid = 1'b0;
      #1;
      chk("ld_rvalid", 32'(ld_rvalid), 32'd1);
      chk("ld_rdata", ld_rdata, 32'h12345678);
      step();
      chk("ld_rvalid_drop", 32'(ld_rvalid), 32'd0);
      chk("ld_rdata_hold", ld_rdata, 32'h12345678);

      // starvation: CPU every cycle, loader read pending
      cpu_memR = 1'b1; cpu_addr = 6'd5;
      ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 6'd10; ld_lock = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("starve_ready_c%0d", c), 32'(ld_ready), 32'(c == 5));
         chk($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), 32'(c == 5));
         step();
      end
      ld_valid = 1'b0;
      #1;
      chk("starve_rvalid", 32'(ld_rvalid), 32'd1);
      chk("starve_rdata", ld_rdata, 32'h12345678);
      chk("starve_resume", 32'(cpu_stall), 32'd0);
      step();

      // lock burst 1,1,0 then a fresh unlocked beat
      b = 0;
      for (int c = 1; c <= 12; c++) begin
         ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 6'(20 + b);
         ld_wdata = 32'hA0 + 32'(b); ld_lock = (b < 2);
         #1;
         chk($sformatf("lock3_ready_c%0d", c), 32'(ld_ready), 32'((c >= 5 && c <= 7) || c == 12));
         chk($sformatf("lock3_stall_c%0d", c), 32'(cpu_stall), 32'((c >= 5 && c <= 7) || c == 12));
         hs = ld_ready;
         step();
         if (hs) b++;
      end
      ld_valid = 1'b0; cpu_addr = 6'd21;
      #1;
      chk("lock3_beats", 32'(b), 32'd4);
      chk("lock3_mem", cpu_rdata, 32'h000000A1);
      step();

      // 12 locked beats with LOCK_MAX=8
      b = 0;
      for (int c = 1; c <= 20; c++) begin
         ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 6'(40 + b);
         ld_wdata = 32'hB0 + 32'(b); ld_lock = 1'b1;
         #1;
         chk($sformatf("lock12_ready_c%0d", c), 32'(ld_ready), 32'((c >= 5 && c <= 12) || c >= 17));
         hs = ld_ready;
         step();
         if (hs) b++;
      end
      // still in lock: idle loader leaves the CPU unstalled
      ld_valid = 1'b0; cpu_addr = 6'd47;
      #1;
      chk("lock12_beats", 32'(b), 32'd12);
      chk("lock_idle_stall", 32'(cpu_stall), 32'd0);
      chk("lock_idle_memrd", 32'(mem_rd), 32'd1);
      chk("lock12_mem", cpu_rdata, 32'h000000B7);
      step();

      // locked read beat, then reset with a write pending
      ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 6'd10; ld_lock = 1'b1;
      #1;
      chk("lock_rd_ready", 32'(ld_ready), 32'd1);
      step();
      ld_we = 1'b1; ld_addr = 6'd30; ld_wdata = 32'hAAAA5555; reset = 1'b1;
      #1;
      chk("mid_rst_rvalid", 32'(ld_rvalid), 32'd1);
      chk("mid_rst_ready", 32'(ld_ready), 32'd0);
      chk("mid_rst_memwr", 32'(mem_wr), 32'd0);
      chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_rvalid", 32'(ld_rvalid), 32'd0);
      chk("post_rst_rdata", ld_rdata, 32'd0);
      chk("post_rst_ready", 32'(ld_ready), 32'd0);
      chk("post_rst_stall", 32'(cpu_stall), 32'd0);
      ld_valid = 1'b0; cpu_addr = 6'd30;
      #1;
      chk("post_rst_mem", cpu_rdata, 32'h0BADF00D);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
